// File: rtl/result_mailbox_monitor.sv
// Watches the core's data port for stores to a result mailbox word and decides pass, fail or
// timeout once the test-completion PC has issued and outstanding stores have had time to land.
module result_mailbox_monitor #(
    parameter logic [31:0] MAILBOX_ADDR   = 32'h80009000,
    parameter logic [31:0] END_PC         = 32'h800000C4,
    parameter logic [31:0] EXPECTED       = 32'hFFFFFFFF,
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] opcode_pc_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] mem_d_addr_i,
    input  logic [31:0] mem_d_data_wr_i,
    input  logic [3:0]  mem_d_wr_i,
    input  logic        mem_d_accept_i,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [31:0] cycle_count_o
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] DrainLen    = 32'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StDone,
        StTimeout
    } state_e;

    state_e      state_q;
    logic [31:0] result_q;
    logic [31:0] result_d;
    logic [31:0] cycle_q;
    logic [31:0] drain_q;
    logic        valid_q;
    logic        done_q;
    logic        pass_q;
    logic        timeout_q;

    logic        active;
    logic        capture;
    logic        end_hit;
    logic        timeout_hit;
    logic        drain_last;

    always_comb begin
        active      = (state_q == StRun) || (state_q == StDrain);
        capture     = active && (mem_d_wr_i != 4'b0000) && mem_d_accept_i &&
                      (mem_d_addr_i[31:2] == MAILBOX_ADDR[31:2]);
        end_hit     = opcode_valid_i && (opcode_pc_i == END_PC);
        timeout_hit = (cycle_q == TimeoutLast);
        drain_last  = ((drain_q + 32'd1) >= DrainLen);

        // Byte-lane merge: only strobed lanes take new data.
        result_d = result_q;
        for (int b = 0; b < 4; b++) begin
            if (capture && mem_d_wr_i[b]) begin
                result_d[8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            result_q  <= 32'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= 32'd0;
            drain_q   <= 32'd0;
        end else begin
            if (capture) begin
                result_q <= result_d;
                valid_q  <= 1'b1;
            end

            if (active && (cycle_q != 32'hFFFFFFFF)) begin
                cycle_q <= cycle_q + 32'd1;
            end

            case (state_q)
                StRun: begin
                    // A completion hit takes priority over a coincident timeout.
                    if (end_hit) begin
                        state_q <= StDrain;
                        drain_q <= 32'd0;
                    end else if (timeout_hit) begin
                        state_q   <= StTimeout;
                        timeout_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        // Judge on the merged value so a store in the last drain cycle counts.
                        pass_q  <= (valid_q || capture) && (result_d == EXPECTED);
                    end else begin
                        drain_q <= drain_q + 32'd1;
                    end
                end
                StDone: begin
                end
                StTimeout: begin
                end
            endcase
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign timeout_o      = timeout_q;
    assign cycle_count_o  = cycle_q;

endmodule

// File: tb/tb_result_mailbox_monitor.sv
// Self-checking bench for result_mailbox_monitor: store vector table, scoreboarded outcomes,
// drain timing, reset recovery and the full-length timeout run.
module tb_result_mailbox_monitor;

    localparam logic [31:0] MBOX = 32'h80009000;
    localparam logic [31:0] EPC  = 32'h800000C4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] opcode_pc;
    logic        opcode_valid;
    logic [31:0] d_addr;
    logic [31:0] d_data;
    logic [3:0]  d_wr;
    logic        d_acc;
    logic [31:0] result;
    logic        result_valid;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    result_mailbox_monitor dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_pc_i    (opcode_pc),
        .opcode_valid_i (opcode_valid),
        .mem_d_addr_i   (d_addr),
        .mem_d_data_wr_i(d_data),
        .mem_d_wr_i     (d_wr),
        .mem_d_accept_i (d_acc),
        .result_o       (result),
        .result_valid_o (result_valid),
        .done_o         (done),
        .pass_o         (pass),
        .timeout_o      (timeout),
        .cycle_count_o  (cycle_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        acc;
        logic [31:0] exp_result;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic        done;
        logic        pass;
        logic        timeout;
        logic [31:0] result;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        opcode_valid = 1'b0;
        opcode_pc    = 32'd0;
        d_addr       = 32'd0;
        d_data       = 32'd0;
        d_wr         = 4'd0;
        d_acc        = 1'b0;
    endtask

    // Reset with live mailbox store and END_PC hit on the inputs; both must be ignored.
    task automatic do_reset(input string tag);
        rst          = 1'b1;
        opcode_valid = 1'b1;
        opcode_pc    = EPC;
        d_addr       = MBOX;
        d_data       = 32'hFFFFFFFF;
        d_wr         = 4'hF;
        d_acc        = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle_inputs();
        check({tag, "_rst_result"}, result, 32'd0);
        check({tag, "_rst_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_rst_done"}, 32'(done), 32'd0);
        check({tag, "_rst_pass"}, 32'(pass), 32'd0);
        check({tag, "_rst_timeout"}, 32'(timeout), 32'd0);
        check({tag, "_rst_count"}, cycle_count, 32'd0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic acc);
        d_addr = addr;
        d_data = data;
        d_wr   = strb;
        d_acc  = acc;
        step();
        d_wr  = 4'd0;
        d_acc = 1'b0;
    endtask

    task automatic hit_end(input logic e_pass, input logic [31:0] e_result);
        exp_t e;
        e.done    = 1'b1;
        e.pass    = e_pass;
        e.timeout = 1'b0;
        e.result  = e_result;
        sb.push_back(e);
        opcode_valid = 1'b1;
        opcode_pc    = EPC;
        step();
        opcode_valid = 1'b0;
    endtask

    task automatic wait_outcome(input string tag, output int lat);
        exp_t e;
        lat = 0;
        while (!(done || timeout) && lat < 60000) begin
            step();
            lat++;
        end
        if (!(done || timeout)) begin
            checks++;
            failures++;
            $display("FAIL %s_wait actual=no_outcome required=done_or_timeout", tag);
        end
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_sb actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_done"}, 32'(done), 32'(e.done));
            check({tag, "_pass"}, 32'(pass), 32'(e.pass));
            check({tag, "_timeout"}, 32'(timeout), 32'(e.timeout));
            check({tag, "_result"}, result, e.result);
        end
    endtask

    vec_t vecs[7];
    int   lat;

    initial begin
        rst = 1'b0;
        idle_inputs();

        vecs[0] = '{MBOX,              32'hFFFFFFFF, 4'hF, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{32'h80009004,      32'hCAFEBABE, 4'hF, 1'b1, 32'h00000000, 1'b0};
        vecs[2] = '{MBOX,              32'h00000011, 4'h1, 1'b1, 32'h00000011, 1'b1};
        vecs[3] = '{MBOX,              32'h00002200, 4'h2, 1'b1, 32'h00002211, 1'b1};
        vecs[4] = '{32'h80009002,      32'h00330000, 4'h4, 1'b1, 32'h00332211, 1'b1};
        vecs[5] = '{MBOX,              32'h44AAAAAA, 4'h8, 1'b1, 32'h44332211, 1'b1};
        vecs[6] = '{MBOX,              32'h00000000, 4'hF, 1'b0, 32'h44332211, 1'b1};

        // Pass run: store, END_PC 10 cycles later, a repeat hit during drain is ignored.
        do_reset("pass");
        store(MBOX, 32'hFFFFFFFF, 4'hF, 1'b1);
        repeat (9) step();
        hit_end(1'b1, 32'hFFFFFFFF);
        opcode_valid = 1'b1;
        opcode_pc    = EPC;
        step();
        opcode_valid = 1'b0;
        wait_outcome("pass", lat);
        check("pass_latency", 32'(lat + 1), 32'd5);
        check("pass_count", cycle_count, 32'd16);
        store(MBOX, 32'h00000000, 4'hF, 1'b1);
        repeat (2) step();
        check("pass_frozen_result", result, 32'hFFFFFFFF);
        check("pass_held_count", cycle_count, 32'd16);

        // Fail run: one bit off.
        do_reset("fail");
        store(MBOX, 32'hFFFF7FFF, 4'hF, 1'b1);
        hit_end(1'b0, 32'hFFFF7FFF);
        wait_outcome("fail", lat);

        // Byte-lane table with rejected stores.
        do_reset("bytes");
        for (int i = 0; i < 7; i++) begin
            store(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].acc);
            check($sformatf("bytes_v%0d_result", i), result, vecs[i].exp_result);
            check($sformatf("bytes_v%0d_valid", i), 32'(result_valid), 32'(vecs[i].exp_valid));
        end
        hit_end(1'b0, 32'h44332211);
        wait_outcome("bytes", lat);

        // Store in the last drain cycle counts; store after done does not.
        do_reset("late");
        hit_end(1'b1, 32'hFFFFFFFF);
        repeat (4) step();
        check("late_not_done_yet", 32'(done), 32'd0);
        store(MBOX, 32'hFFFFFFFF, 4'hF, 1'b1);
        wait_outcome("late", lat);
        store(MBOX, 32'h12345678, 4'hF, 1'b1);
        check("late_post_done_store", result, 32'hFFFFFFFF);

        // No mailbox store at all.
        do_reset("nostore");
        hit_end(1'b0, 32'h00000000);
        wait_outcome("nostore", lat);
        check("nostore_valid", 32'(result_valid), 32'd0);

        // Reset mid-drain, then a clean rerun.
        do_reset("middrain");
        store(MBOX, 32'hFFFFFFFF, 4'hF, 1'b1);
        opcode_valid = 1'b1;
        opcode_pc    = EPC;
        step();
        opcode_valid = 1'b0;
        repeat (2) step();
        do_reset("middrain2");
        store(MBOX, 32'hFFFFFFFF, 4'hF, 1'b1);
        hit_end(1'b1, 32'hFFFFFFFF);
        wait_outcome("rerun", lat);

        // Full-length timeout run.
        do_reset("timeout");
        begin
            exp_t e;
            e.done    = 1'b0;
            e.pass    = 1'b0;
            e.timeout = 1'b1;
            e.result  = 32'd0;
            sb.push_back(e);
        end
        wait_outcome("timeout", lat);
        check("timeout_latency", 32'(lat), 32'd50000);
        check("timeout_count", cycle_count, 32'd50000);
        opcode_valid = 1'b1;
        opcode_pc    = EPC;
        repeat (10) step();
        opcode_valid = 1'b0;
        check("timeout_terminal_done", 32'(done), 32'd0);
        check("timeout_terminal_flag", 32'(timeout), 32'd1);
        check("timeout_held_count", cycle_count, 32'd50000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_mailbox_monitor.md
RESULT_MAILBOX_MONITOR -- requirements
Module: result_mailbox_monitor

Interface
REQ-001 SHALL have parameter MAILBOX_ADDR, default 32'h80009000, byte address of the 32-bit result mailbox word.
REQ-002 SHALL have parameter END_PC, default 32'h800000C4, PC of the test-completion instruction.
REQ-003 SHALL have parameter EXPECTED, default 32'hFFFFFFFF, the mailbox value that means pass.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 5, cycles to wait after END_PC for stores to land.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 50000, cycle budget before timeout.
REQ-006 SHALL have ports: clk_i  input  1  clock; all logic on rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 opcode_pc_i  input  32  PC of the instruction in execute.
REQ-009 opcode_valid_i  input  1  opcode_pc_i qualifies a real issued instruction.
REQ-010 mem_d_addr_i  input  32  core data-port address.
REQ-011 mem_d_data_wr_i  input  32  core store data.
REQ-012 mem_d_wr_i  input  4  byte write strobes; nonzero means store.
REQ-013 mem_d_accept_i  input  1  memory accepts the current data request.
REQ-014 result_o  output  32  captured mailbox value.
REQ-015 result_valid_o  output  1  at least one mailbox store captured.
REQ-016 done_o  output  1  test completed normally (sticky).
REQ-017 pass_o  output  1  done_o and result matches EXPECTED (sticky).
REQ-018 timeout_o  output  1  cycle budget exhausted before completion (sticky).
REQ-019 cycle_count_o  output  32  cycles spent in RUN and DRAIN.

Function
REQ-020 SHALL implement FSM states RUN, DRAIN, DONE, TIMEOUT; reset state RUN.
REQ-021 Store capture: a cycle with mem_d_wr_i != 0, mem_d_accept_i = 1 and mem_d_addr_i[31:2] == MAILBOX_ADDR[31:2] SHALL update result_o bytes whose strobe bit is set, others unchanged, visible next cycle.
REQ-022 Capture SHALL occur in RUN and DRAIN only; result_o frozen in DONE and TIMEOUT.
REQ-023 result_valid_o SHALL set on the first capture and stay set until reset.
REQ-024 Stores with mem_d_accept_i = 0, or to any other word address, SHALL be ignored.
REQ-025 RUN -> DRAIN when opcode_valid_i = 1 and opcode_pc_i == END_PC; drain counter loads 0.
REQ-026 DRAIN SHALL count DRAIN_CYCLES cycles then enter DONE; later END_PC hits ignored.
REQ-027 RUN -> TIMEOUT when cycle_count_o == TIMEOUT_CYCLES-1 and no END_PC hit that cycle.
REQ-028 Simultaneous END_PC hit and timeout condition in RUN: END_PC SHALL win (enter DRAIN).
REQ-029 DRAIN SHALL not time out; the timeout applies in RUN only.
REQ-030 cycle_count_o SHALL increment by 1 each cycle in RUN or DRAIN, hold in DONE/TIMEOUT, saturate at 32'hFFFFFFFF.
REQ-031 On the DRAIN -> DONE transition, done_o SHALL rise, and pass_o SHALL be set the same cycle iff result_valid_o = 1 and result_o (including any capture in the final DRAIN cycle) == EXPECTED.
REQ-032 A run with no mailbox store SHALL finish with done_o = 1, pass_o = 0.
REQ-033 DONE and TIMEOUT SHALL be terminal until reset; done_o and timeout_o never both 1.

Reset
REQ-034 rst_i high at a clock edge SHALL force: state RUN, result_o 0, result_valid_o 0, done_o 0, pass_o 0, timeout_o 0, cycle_count_o 0, drain counter 0, from any state including mid-DRAIN.
REQ-035 Inputs SHALL be ignored in any cycle with rst_i high; counting restarts from 0 the first cycle after rst_i falls.

Verification
REQ-036 Store 0xFFFFFFFF, strobe 4'hF, accepted, to 0x80009000; END_PC hit 10 cycles later -> done_o=1 exactly 5 cycles after the hit, pass_o=1, result_o=0xFFFFFFFF.
REQ-037 Store 0xFFFF7FFF to mailbox then END_PC -> done_o=1, pass_o=0, result_o=0xFFFF7FFF.
REQ-038 Byte stores 0x11/0x22/0x33/0x44 on strobes 1,2,4,8, plus one store with accept=0 and one to 0x80009004 -> result_o=0x44332211; rejected stores leave no effect.
REQ-039 No END_PC for 50000 cycles, TIMEOUT_CYCLES=50000 -> timeout_o=1, done_o=0, cycle_count_o=50000 and held.
REQ-040 Mailbox store issued on the 5th DRAIN cycle -> captured and used for pass_o; store one cycle after done_o -> ignored.
REQ-041 rst_i asserted during DRAIN with result captured -> all outputs 0 next cycle; normal rerun passes.
